ext_irq_ctrl: RTL and testbench

//  External interrupt controller: the source side of the processor's ExtIRQ/ExtIAck handshake.
//  - Edge-detects NSRC peripheral interrupt lines and latches them as pending.
//  - Picks one eligible source by fixed priority and drives ExtIRQ until the core answers with ExtIAck.
//  - Exposes the serviced source id to the exception handler, then retires it.
//  - Sits beside processor_arm at top level, clocked with the core.

---
 rtl/ext_irq_ctrl.sv | 71 +++++++
 tb/tb_ext_irq_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ext_irq_ctrl.sv
// ext_irq_ctrl: edge-latched fixed-priority ExtIRQ/ExtIAck source; IRQ_TIMEOUT_EN adds request timeout
module ext_irq_ctrl #(
  parameter int NSRC = 4,
  parameter int HOLDOFF = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NSRC-1:0]         src_irq,
  input  logic [NSRC-1:0]         irq_mask,
  output logic                    ExtIRQ,
  input  logic                    ExtIAck,
  output logic [$clog2(NSRC)-1:0] irq_id,
  output logic                    irq_valid,
  output logic [NSRC-1:0]         pending,
  output logic                    timeout_err
);
  localparam int IW = $clog2(NSRC);
  localparam int CW = $clog2((HOLDOFF > TIMEOUT ? HOLDOFF : TIMEOUT) + 2);
  typedef enum logic [1:0] {IDLE, REQ, ACK, HOLD} state_t;
  state_t state, state_nxt;
  logic [NSRC-1:0] src_prev, eligible, clr;
  logic [IW-1:0] winner;
  logic [CW-1:0] cnt;
  logic hold_done, timed_out;
  assign eligible = pending & irq_mask;
  assign hold_done = HOLDOFF == 0 || cnt == CW'(HOLDOFF - 1);
  assign clr = (state == REQ && ExtIAck) ? NSRC'(1) << irq_id : '0;
`ifdef IRQ_TIMEOUT_EN
  assign timed_out = state == REQ && !ExtIAck && cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk)
    if (reset) timeout_err <= 1'b0;
    else if (timed_out) timeout_err <= 1'b1;
`else
  assign timed_out = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_comb begin
    winner = '0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (eligible[i]) winner = IW'(i);
  end
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = |eligible ? REQ : IDLE;
      REQ:  state_nxt = ExtIAck ? ACK : timed_out ? HOLD : REQ;
      ACK:  state_nxt = ExtIAck ? ACK : HOLDOFF > 0 ? HOLD : IDLE;
      HOLD: state_nxt = hold_done ? IDLE : HOLD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      src_prev <= '0;
      pending <= '0;
      cnt <= '0;
      ExtIRQ <= 1'b0;
      irq_valid <= 1'b0;
      irq_id <= '0;
    end else begin
      state <= state_nxt;
      src_prev <= src_irq;
      pending <= (pending & ~clr) | (src_irq & ~src_prev);
      cnt <= state_nxt != state ? '0 : cnt + CW'(1);
      ExtIRQ <= state_nxt == REQ;
      irq_valid <= state_nxt == REQ || state_nxt == ACK;
      irq_id <= state == IDLE ? winner : (state_nxt == REQ || state_nxt == ACK) ? irq_id : '0;
    end
  end
endmodule

// File: tb/tb_ext_irq_ctrl.sv
// tb_ext_irq_ctrl: directed scoreboard bench for ext_irq_ctrl
module tb_ext_irq_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] src_irq, irq_mask, pending;
  logic ExtIRQ, ExtIAck, irq_valid, timeout_err;
  logic [1:0] irq_id;
  int checks = 0;
  int errors = 0;
  int exp_ids[$];
  ext_irq_ctrl #(
    .NSRC(4),
    .HOLDOFF(2),
`ifdef IRQ_TIMEOUT_EN
    .TIMEOUT(8)
`else
    .TIMEOUT(255)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .src_irq(src_irq),
    .irq_mask(irq_mask),
    .ExtIRQ(ExtIRQ),
    .ExtIAck(ExtIAck),
    .irq_id(irq_id),
    .irq_valid(irq_valid),
    .pending(pending),
    .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic pop_chk(input string tag);
    int e;
    checks++;
    if (exp_ids.size() == 0) begin
      errors++;
      $error("FAIL %s got id %0d exp none queued", tag, irq_id);
    end else begin
      e = exp_ids.pop_front();
      assert (irq_id === 2'(e) && irq_valid === 1'b1) else begin
        errors++;
        $error("FAIL %s got id %0d valid %0b exp id %0d valid 1", tag, irq_id, irq_valid, e);
      end
    end
  endtask
  task automatic handshake(input string tag);
    ExtIAck = 1'b1;
    tick();
    chk({tag, "_ack_irq"}, 32'(ExtIRQ), 0);
    chk({tag, "_ack_valid"}, 32'(irq_valid), 1);
    ExtIAck = 1'b0;
    tick();
    chk({tag, "_hold_valid"}, 32'(irq_valid), 0);
    chk({tag, "_hold_id"}, 32'(irq_id), 0);
  endtask
  initial begin
    reset = 1'b1;
    src_irq = '0;
    irq_mask = '0;
    ExtIAck = 1'b0;
    tick();
    tick();
    chk("rst_irq", 32'(ExtIRQ), 0);
    chk("rst_pend", 32'(pending), 0);
    chk("rst_valid", 32'(irq_valid), 0);
    chk("rst_id", 32'(irq_id), 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_irq", 32'(ExtIRQ), 0);
      chk("idle_pend", 32'(pending), 0);
    end
    chk("idle_terr", 32'(timeout_err), 0);
    irq_mask = 4'hF;
    src_irq = 4'b0100;
    exp_ids.push_back(2);
    tick();
    chk("t2_pend", 32'(pending), 4);
    chk("t2_irq_early", 32'(ExtIRQ), 0);
    tick();
    chk("t2_irq", 32'(ExtIRQ), 1);
    pop_chk("t2_id");
    src_irq = '0;
    handshake("t2");
    chk("t2_pend_clr", 32'(pending), 0);
    tick();
    tick();
    src_irq = 4'b1010;
    exp_ids.push_back(1);
    exp_ids.push_back(3);
    tick();
    chk("t3_pend", 32'(pending), 4'hA);
    tick();
    chk("t3_irq1", 32'(ExtIRQ), 1);
    pop_chk("t3_id1");
    src_irq = '0;
    handshake("t3a");
    chk("t3_pend_mid", 32'(pending), 4'h8);
    for (int i = 0; i < 3; i++) begin
      chk("t3_holdoff", 32'(ExtIRQ), 0);
      tick();
    end
    chk("t3_irq3", 32'(ExtIRQ), 1);
    pop_chk("t3_id3");
    handshake("t3b");
    chk("t3_pend_end", 32'(pending), 0);
    tick();
    tick();
    irq_mask = 4'b0111;
    src_irq = 4'b1000;
    tick();
    chk("t4_pend", 32'(pending), 4'h8);
    src_irq = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_masked", 32'(ExtIRQ), 0);
    end
    irq_mask = 4'hF;
    exp_ids.push_back(3);
    tick();
    chk("t4_irq", 32'(ExtIRQ), 1);
    pop_chk("t4_id");
    irq_mask = 4'h0;
    tick();
    chk("t4_frozen_irq", 32'(ExtIRQ), 1);
    chk("t4_frozen_id", 32'(irq_id), 3);
    irq_mask = 4'hF;
    handshake("t4");
    tick();
    tick();
    ExtIAck = 1'b1;
    tick();
    chk("idle_ack_irq", 32'(ExtIRQ), 0);
    chk("idle_ack_pend", 32'(pending), 0);
    ExtIAck = 1'b0;
    src_irq = 4'b0001;
    exp_ids.push_back(0);
    exp_ids.push_back(0);
    tick();
    chk("t5_pend", 32'(pending), 1);
    src_irq = '0;
    tick();
    chk("t5_irq", 32'(ExtIRQ), 1);
    pop_chk("t5_id_a");
    src_irq = 4'b0001;
    ExtIAck = 1'b1;
    tick();
    chk("t5_set_wins", 32'(pending), 1);
    chk("t5_ack_irq", 32'(ExtIRQ), 0);
    src_irq = '0;
    ExtIAck = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("t5_irq2", 32'(ExtIRQ), 1);
    pop_chk("t5_id_b");
    handshake("t5");
    chk("t5_pend_end", 32'(pending), 0);
    tick();
    tick();
`ifdef IRQ_TIMEOUT_EN
    src_irq = 4'b0100;
    exp_ids.push_back(2);
    exp_ids.push_back(2);
    tick();
    src_irq = '0;
    tick();
    chk("t6_irq", 32'(ExtIRQ), 1);
    pop_chk("t6_id_a");
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t6_req_hold", 32'(ExtIRQ), 1);
    end
    tick();
    chk("t6_dropped", 32'(ExtIRQ), 0);
    chk("t6_terr", 32'(timeout_err), 1);
    chk("t6_pend_kept", 32'(pending), 4);
    tick();
    tick();
    tick();
    chk("t6_rereq", 32'(ExtIRQ), 1);
    pop_chk("t6_id_b");
    reset = 1'b1;
    tick();
    chk("t6_rst_irq", 32'(ExtIRQ), 0);
    chk("t6_rst_terr", 32'(timeout_err), 0);
    chk("t6_rst_pend", 32'(pending), 0);
    reset = 1'b0;
    tick();
`else
    chk("no_terr", 32'(timeout_err), 0);
`endif
    src_irq = 4'b0010;
    exp_ids.push_back(1);
    tick();
    tick();
    chk("midreq_irq", 32'(ExtIRQ), 1);
    pop_chk("midreq_id");
    reset = 1'b1;
    tick();
    chk("midreq_rst_irq", 32'(ExtIRQ), 0);
    chk("midreq_rst_valid", 32'(irq_valid), 0);
    chk("midreq_rst_id", 32'(irq_id), 0);
    chk("midreq_rst_pend", 32'(pending), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("held_line_edge", 32'(pending), 2);
    src_irq = '0;
    tick();
    chk("held_line_irq", 32'(ExtIRQ), 1);
    chk("held_line_id", 32'(irq_id), 1);
    handshake("final");
    chk("final_pend", 32'(pending), 0);
    chk("sb_empty", 32'(exp_ids.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
